// File: rtl/glitc_intercom_cmd_decoder.sv
// GLITC intercom receive-side command decoder.
// Acquires link lock on idle characters and decodes complement-protected
// command pairs. Header byte {4'hA, code} must be followed by its bitwise
// inverse; the code then becomes a one-cycle sync pulse or command strobe.
//
// Optional build macro GLITC_INTERCOM_CMD_STRICT_EN: when defined, an idle
// byte arriving between header and complement counts as a mismatch.
// When undefined, such idles are skipped and the command stays pending.
//
// state  | meaning
// HUNT   | searching for first idle character
// VERIFY | counting consecutive idles towards lock
// LOCKED | link up, waiting for idle or command header
// CMD    | header latched, waiting for its complement byte
module glitc_intercom_cmd_decoder #(
  parameter int          LOCK_COUNT   = 16,
  parameter int          UNLOCK_COUNT = 4,
  parameter logic [7:0]  IDLE_CHAR    = 8'hBC,
  parameter logic [3:0]  SYNC_CODE    = 4'h1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        status_rst_i,
  output logic        sync_o,
  output logic [3:0]  cmd_o,
  output logic        cmd_valid_o,
  output logic        locked_o,
  output logic [15:0] err_count_o
);

`ifdef GLITC_INTERCOM_CMD_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, CMD} state_t;

  state_t     state;
  logic [7:0] lock_cnt;
  logic [3:0] consec_err;
  logic [3:0] hdr_code;

  logic is_idle;
  logic is_hdr;
  logic cmp_match;
  logic byte_err;
  logic byte_good;

  assign is_idle   = (rx_data_i == IDLE_CHAR);
  assign is_hdr    = (rx_data_i[7:4] == 4'hA);
  assign cmp_match = (rx_data_i == ~{4'hA, hdr_code});

  // Classify the current byte as good/errored; only meaningful once locked.
  always_comb begin
    byte_err  = 1'b0;
    byte_good = 1'b0;
    case (state)
      LOCKED: begin
        if (is_idle || is_hdr) byte_good = 1'b1;
        else                   byte_err  = 1'b1;
      end
      CMD: begin
        if (cmp_match)              byte_good = 1'b1;
        else if (is_idle && !STRICT) byte_good = 1'b0;
        else                        byte_err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Link FSM, command decode, error counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= HUNT;
      lock_cnt    <= '0;
      consec_err  <= '0;
      hdr_code    <= '0;
      sync_o      <= 1'b0;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      locked_o    <= 1'b0;
      err_count_o <= '0;
    end else begin
      sync_o      <= 1'b0;
      cmd_valid_o <= 1'b0;

      if (status_rst_i)
        err_count_o <= '0;
      else if (rx_valid_i && byte_err && (err_count_o != 16'hFFFF))
        err_count_o <= err_count_o + 16'd1;

      if (rx_valid_i) begin
        if (byte_err) begin
          // An errored complement also drops the pending command.
          if (consec_err == 4'(UNLOCK_COUNT - 1)) begin
            state      <= HUNT;
            locked_o   <= 1'b0;
            consec_err <= '0;
            lock_cnt   <= '0;
          end else begin
            consec_err <= consec_err + 4'd1;
            state      <= LOCKED;
          end
        end else begin
          if (byte_good) consec_err <= '0;
          case (state)
            HUNT: begin
              if (is_idle) begin
                state    <= VERIFY;
                lock_cnt <= 8'd1;
              end
            end
            VERIFY: begin
              if (!is_idle) begin
                state    <= HUNT;
                lock_cnt <= '0;
              end else if (lock_cnt == 8'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                lock_cnt <= '0;
              end else begin
                lock_cnt <= lock_cnt + 8'd1;
              end
            end
            LOCKED: begin
              if (is_hdr && !is_idle) begin
                hdr_code <= rx_data_i[3:0];
                state    <= CMD;
              end
            end
            CMD: begin
              if (cmp_match) begin
                state <= LOCKED;
                if (hdr_code == SYNC_CODE) begin
                  sync_o <= 1'b1;
                end else begin
                  cmd_valid_o <= 1'b1;
                  cmd_o       <= hdr_code;
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_glitc_intercom_cmd_decoder.sv
// Scoreboard bench for glitc_intercom_cmd_decoder. Expected pulses are
// queued by the stimulus thread and popped by a monitor on every pulse.
// A second instance with a wider unlock window exercises err_count_o
// saturation without losing lock.
module tb_glitc_intercom_cmd_decoder;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        status_rst_i;
  logic        sync_o;
  logic [3:0]  cmd_o;
  logic        cmd_valid_o;
  logic        locked_o;
  logic [15:0] err_count_o;

  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_srst;
  logic        s_sync;
  logic [3:0]  s_cmd;
  logic        s_cmd_valid;
  logic        s_locked;
  logic [15:0] s_err;

  int n_cmp = 0;
  int n_mis = 0;
  int s_pulses = 0;
  logic [4:0] exp_q[$];

`ifdef GLITC_INTERCOM_CMD_STRICT_EN
  localparam int E0 = 5;
`else
  localparam int E0 = 3;
`endif

  always #5 clk_i = ~clk_i;

  glitc_intercom_cmd_decoder dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .status_rst_i(status_rst_i),
    .sync_o(sync_o), .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o),
    .locked_o(locked_o), .err_count_o(err_count_o)
  );

  glitc_intercom_cmd_decoder #(.LOCK_COUNT(2), .UNLOCK_COUNT(15)) dut_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(s_data),
    .rx_valid_i(s_valid), .status_rst_i(s_srst),
    .sync_o(s_sync), .cmd_o(s_cmd), .cmd_valid_o(s_cmd_valid),
    .locked_o(s_locked), .err_count_o(s_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one valid byte; called at a negedge, returns at the next negedge.
  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  // Monitor: each pulse cycle pops one expected {is_sync, code} entry.
  always @(negedge clk_i) begin
    if (sync_o || cmd_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_pulse: got sync=%0b cmd_valid=%0b cmd=%0h expected none",
                 sync_o, cmd_valid_o, cmd_o);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, sync_o, cmd_valid_o}, {30'd0, e[4], ~e[4]});
        if (!e[4]) check("pulse_code", {28'd0, cmd_o}, {28'd0, e[3:0]});
      end
    end
    if (s_sync || s_cmd_valid) s_pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; status_rst_i = 1'b0;
    s_data = '0; s_valid = 1'b0; s_srst = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_sync", {31'd0, sync_o}, 0);
    check("rst_cmd_valid", {31'd0, cmd_valid_o}, 0);
    check("rst_cmd", {28'd0, cmd_o}, 0);
    check("rst_locked", {31'd0, locked_o}, 0);
    check("rst_err", {16'd0, err_count_o}, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Lock acquisition: 15 idles then a break never locks.
    send_n(8'hBC, 15);
    check("lock_15_no", {31'd0, locked_o}, 0);
    send(8'h00);
    check("lock_break", {31'd0, locked_o}, 0);
    send_n(8'hBC, 15);
    check("lock_15_again", {31'd0, locked_o}, 0);
    send(8'hBC);
    check("lock_16", {31'd0, locked_o}, 1);

    // Sync command.
    send(8'hA1);
    exp_q.push_back({1'b1, 4'h1});
    send(8'h5E);
    @(negedge clk_i);
    check("sync_err", {16'd0, err_count_o}, 0);

    // General command with gap, then a bad complement.
    send(8'hA7);
    repeat (3) @(negedge clk_i);
    exp_q.push_back({1'b0, 4'h7});
    send(8'h58);
    send(8'hA7);
    send(8'h00);
    check("bad_cmp_err", {16'd0, err_count_o}, 1);
    check("cmd_hold", {28'd0, cmd_o}, 7);

    // Header as complement is an error and not reinterpreted.
    send(8'hA1);
    send(8'hA2);
    send(8'h5D);
    check("hdr_as_cmp_err", {16'd0, err_count_o}, 3);
    check("hdr_as_cmp_lock", {31'd0, locked_o}, 1);

    // Idle between header and complement.
    send(8'hA1);
    send(8'hBC);
`ifndef GLITC_INTERCOM_CMD_STRICT_EN
    exp_q.push_back({1'b1, 4'h1});
`endif
    send(8'h5E);
    @(negedge clk_i);
    check("idle_in_cmd_err", {16'd0, err_count_o}, E0);

    // Good bytes clear the consecutive error count.
    send(8'hBC);
    send_n(8'h00, 3);
    send(8'hBC);
    send_n(8'h00, 3);
    check("consec_clear_lock", {31'd0, locked_o}, 1);
    check("consec_clear_err", {16'd0, err_count_o}, E0 + 6);

    // Four consecutive errors drop lock.
    send(8'hBC);
    send_n(8'h00, 3);
    check("unlock_3", {31'd0, locked_o}, 1);
    send(8'h00);
    check("unlock_4", {31'd0, locked_o}, 0);
    check("unlock_err", {16'd0, err_count_o}, E0 + 10);
    send_n(8'h00, 3);
    send(8'hBC);
    check("hunt_no_err", {16'd0, err_count_o}, E0 + 10);
    send_n(8'hBC, 14);
    check("relock_15", {31'd0, locked_o}, 0);
    send(8'hBC);
    check("relock_16", {31'd0, locked_o}, 1);

    // Status clear alone.
    status_rst_i = 1'b1;
    @(negedge clk_i);
    status_rst_i = 1'b0;
    check("status_clear", {16'd0, err_count_o}, 0);

    // Reset between header and complement: no pulse afterwards.
    send(8'hA3);
    #2 rst_n_i = 1'b0;
    @(negedge clk_i);
    check("midrst_locked", {31'd0, locked_o}, 0);
    rst_n_i = 1'b1;
    send(8'h5C);
    repeat (2) @(negedge clk_i);
    check("midrst_err", {16'd0, err_count_o}, 0);
    check("queue_empty", exp_q.size(), 0);

    // Saturation on the wide-window instance: 14 errors + 1 idle keeps lock.
    s_valid = 1'b1;
    s_data  = 8'hBC;
    repeat (2) @(negedge clk_i);
    check("sat_lock", {31'd0, s_locked}, 1);
    for (int i = 0; i < 4681; i++) begin
      s_data = 8'h00;
      repeat (14) @(negedge clk_i);
      s_data = 8'hBC;
      @(negedge clk_i);
    end
    check("sat_fffe", {16'd0, s_err}, 32'hFFFE);
    s_data = 8'h00;
    @(negedge clk_i);
    check("sat_ffff", {16'd0, s_err}, 32'hFFFF);
    repeat (2) @(negedge clk_i);
    check("sat_hold", {16'd0, s_err}, 32'hFFFF);
    s_srst = 1'b1;
    @(negedge clk_i);
    check("clear_wins", {16'd0, s_err}, 0);
    s_srst  = 1'b0;
    s_valid = 1'b0;
    @(negedge clk_i);
    check("sat_locked_kept", {31'd0, s_locked}, 1);
    check("sat_no_pulses", s_pulses, 0);
    check("sat_cmd", {28'd0, s_cmd}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
